pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipelined CPU. It drives the hold (`WEN`) and squash inputs of the PC and the IF/ID and ID/EX pipeline registers. It selects EX-stage operand forwarding and sequences the halt drain. It also keeps saturating stall and flush performance counters. It sits beside the datapath in the CPU top and replaces the constant `1'b0` hold ties.

---
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and halt-drain sequencing for the five-stage pipeline.
// Drives PC / IF-ID / ID-EX hold and squash, plus saturating perf counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic             id_halt,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_valid,
   input  logic             ex_is_load,
   input  logic             ex_reg_write,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic             ex_redirect,
   input  logic             mem_valid,
   input  logic             mem_reg_write,
   input  logic [4:0]       mem_rd,
   input  logic             wb_valid,
   input  logic             wb_reg_write,
   input  logic             wb_halt,
   input  logic [4:0]       wb_rd,
   output logic             pc_hold,
   output logic             if_id_wen,
   output logic             id_ex_wen,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t state, state_n;
   logic   lu;
   logic   wb_done;
   logic   halt_go;
   logic   stall_inc;
   logic   flush_inc;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (mem_valid && mem_reg_write && mem_rd != 5'd0 && mem_rd == rs)
         return 2'b01;
      else if (wb_valid && wb_reg_write && wb_rd != 5'd0 && wb_rd == rs)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   assign lu = id_valid && ex_valid && ex_is_load && ex_reg_write &&
               ex_rd != 5'd0 &&
               ((id_uses_rs1 && id_rs1 == ex_rd) ||
                (id_uses_rs2 && id_rs2 == ex_rd));

   assign wb_done   = wb_valid && wb_halt;
   assign halt_go   = id_valid && id_halt && !ex_redirect && !lu;
   assign stall_inc = (state == RUN) && !rst && !ex_redirect && lu;
   assign flush_inc = (state != HALTED) && !rst && ex_redirect;

   always_comb begin
      pc_hold     = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_wen   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      fwd_a_sel   = rst ? 2'b00 : fwd_sel(ex_rs1);
      fwd_b_sel   = rst ? 2'b00 : fwd_sel(ex_rs2);
      if (state == HALTED) begin
         pc_hold     = 1'b1;
         if_id_wen   = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (rst || ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (state == DRAIN) begin
         pc_hold     = 1'b1;
         if_id_flush = 1'b1;
      end else if (lu) begin
         pc_hold     = 1'b1;
         if_id_wen   = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   // A halt reaching WB always wins, even if the drain was never entered.
   always_comb begin
      state_n = state;
      unique case (state)
         RUN: begin
            if (wb_done)
               state_n = HALTED;
            else if (halt_go)
               state_n = DRAIN;
         end
         DRAIN: begin
            if (wb_done)
               state_n = HALTED;
         end
         HALTED:  state_n = HALTED;
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         halted      <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state  <= state_n;
         halted <= (state_n == HALTED);
         if (stall_inc && stall_count != '1)
            stall_count <= stall_count + 1'b1;
         if (flush_inc && flush_count != '1)
            flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a
// rule-level reference model (4-bit counters to reach saturation quickly).
module tb_pipeline_hazard_ctrl;

   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   logic id_valid, id_halt, id_uses_rs1, id_uses_rs2;
   logic [4:0] id_rs1, id_rs2;
   logic ex_valid, ex_is_load, ex_reg_write, ex_redirect;
   logic [4:0] ex_rd, ex_rs1, ex_rs2;
   logic mem_valid, mem_reg_write;
   logic [4:0] mem_rd;
   logic wb_valid, wb_reg_write, wb_halt;
   logic [4:0] wb_rd;
   logic pc_hold, if_id_wen, id_ex_wen, if_id_flush, id_ex_flush;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic halted;
   logic [CW-1:0] stall_count, flush_count;

   int checks = 0;
   int errors = 0;

   // Model state: 0 run, 1 drain, 2 halted.
   int m_mode = 0;
   int m_stall = 0;
   int m_flush = 0;
   bit m_halted = 0;

   pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_halt(id_halt),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load),
      .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_redirect(ex_redirect),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_halt(wb_halt), .wb_rd(wb_rd),
      .pc_hold(pc_hold), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .halted(halted), .stall_count(stall_count),
      .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit m_lu();
      return id_valid && ex_valid && ex_is_load && ex_reg_write &&
             ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) ||
              (id_uses_rs2 && id_rs2 == ex_rd));
   endfunction

   function automatic int m_fwd(input int rs);
      if (rst) return 0;
      if (mem_valid && mem_reg_write && mem_rd != 0 && mem_rd == rs)
         return 1;
      if (wb_valid && wb_reg_write && wb_rd != 0 && wb_rd == rs)
         return 2;
      return 0;
   endfunction

   // Returns {pc_hold, if_id_wen, id_ex_wen, if_id_flush, id_ex_flush}.
   function automatic int m_ctl();
      if (m_mode == 2) return 5'b11011;
      if (rst) return 5'b00011;
      if (ex_redirect) return 5'b00011;
      if (m_mode == 1) return 5'b10010;
      if (m_lu()) return 5'b11001;
      return 5'b00000;
   endfunction

   task automatic clear();
      rst = 0;
      id_valid = 0; id_halt = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_rs1 = 0; id_rs2 = 0;
      ex_valid = 0; ex_is_load = 0; ex_reg_write = 0; ex_redirect = 0;
      ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
      mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
      wb_valid = 0; wb_reg_write = 0; wb_halt = 0; wb_rd = 0;
   endtask

   task automatic set_lu(input logic [4:0] r);
      id_valid = 1; id_uses_rs1 = 1; id_rs1 = r;
      ex_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = r;
   endtask

   // One cycle: check combinational outputs, clock, update model, check regs.
   task automatic cyc(input string tag);
      bit lu_now;
      #2;
      lu_now = m_lu();
      chk({tag, ":ctl"},
          {pc_hold, if_id_wen, id_ex_wen, if_id_flush, id_ex_flush},
          m_ctl());
      chk({tag, ":fwd_a"}, fwd_a_sel, m_fwd(ex_rs1));
      chk({tag, ":fwd_b"}, fwd_b_sel, m_fwd(ex_rs2));
      @(posedge clk);
      if (rst) begin
         m_mode = 0; m_stall = 0; m_flush = 0;
      end else if (m_mode != 2) begin
         if (ex_redirect)
            m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
         else if (m_mode == 0 && lu_now)
            m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
         if (wb_valid && wb_halt)
            m_mode = 2;
         else if (m_mode == 0 && id_valid && id_halt &&
                  !ex_redirect && !lu_now)
            m_mode = 1;
      end
      m_halted = (m_mode == 2);
      #1;
      chk({tag, ":halted"}, halted, m_halted);
      chk({tag, ":stall_cnt"}, stall_count, m_stall);
      chk({tag, ":flush_cnt"}, flush_count, m_flush);
   endtask

   initial begin
      clear();
      rst = 1;
      @(negedge clk);
      cyc("reset0");
      rst = 0;
      chk("reset_stall_zero", stall_count, 0);
      chk("reset_not_halted", halted, 0);

      // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
      set_lu(5'd5); id_rs2 = 5'd1; id_uses_rs2 = 1;
      cyc("lu_stall");
      chk("lu_pc_hold", pc_hold, 1);
      chk("lu_stall_cnt", stall_count, 1);
      clear();
      mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd5;
      ex_valid = 1; ex_rs1 = 5'd5; ex_rs2 = 5'd1;
      cyc("lu_after");
      chk("lu_after_fwd_a", fwd_a_sel, 1);

      // Forwarding priority and x0.
      clear();
      mem_valid = 1; mem_reg_write = 1; mem_rd = 5'd7;
      wb_valid = 1; wb_reg_write = 1; wb_rd = 5'd7;
      ex_rs1 = 5'd7; ex_rs2 = 5'd7;
      cyc("fwd_prio");
      mem_rd = 5'd3;
      cyc("fwd_wb");
      mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
      cyc("fwd_x0");

      // Redirect beats load-use.
      clear();
      set_lu(5'd9); ex_redirect = 1;
      cyc("redir_lu");
      chk("redir_pc_hold", pc_hold, 0);

      // Build stall_count=3 first, then drain and reset mid-drain.
      clear(); rst = 1; cyc("rst_a"); clear();
      for (int i = 0; i < 3; i++) begin
         set_lu(5'd4); cyc("lu3");
      end
      clear(); id_valid = 1; id_halt = 1;
      cyc("halt_id");
      clear(); set_lu(5'd2); ex_redirect = 1;
      cyc("drain_redir");
      clear(); set_lu(5'd2);
      cyc("drain_lu");
      clear(); rst = 1;
      cyc("rst_drain");
      clear();
      cyc("post_rst");

      // Halt drain to HALTED, then hold.
      id_valid = 1; id_halt = 1;
      cyc("halt2_id");
      clear();
      cyc("drain1");
      cyc("drain2");
      wb_valid = 1; wb_halt = 1;
      cyc("wb_halt");
      chk("halted_rise", halted, 1);
      clear();
      for (int i = 0; i < 10; i++) begin
         set_lu(5'd6); ex_redirect = i[0];
         cyc("halted_hold");
      end
      clear(); rst = 1; cyc("rst_halt"); clear();

      // Saturation: hold lu for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         set_lu(5'd8); cyc("sat");
      end
      chk("sat_value", stall_count, CMAX);

      // Randomized traffic on a small register range to force collisions.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) == 0);
         id_valid = $urandom; id_halt = ($urandom_range(0, 15) == 0);
         id_rs1 = 5'($urandom_range(0, 3));
         id_rs2 = 5'($urandom_range(0, 3));
         id_uses_rs1 = $urandom; id_uses_rs2 = $urandom;
         ex_valid = $urandom; ex_is_load = $urandom;
         ex_reg_write = $urandom;
         ex_rd = 5'($urandom_range(0, 3));
         ex_rs1 = 5'($urandom_range(0, 3));
         ex_rs2 = 5'($urandom_range(0, 3));
         ex_redirect = ($urandom_range(0, 5) == 0);
         mem_valid = $urandom; mem_reg_write = $urandom;
         mem_rd = 5'($urandom_range(0, 3));
         wb_valid = $urandom; wb_reg_write = $urandom;
         wb_halt = ($urandom_range(0, 30) == 0);
         wb_rd = 5'($urandom_range(0, 3));
         cyc("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
